truth_table_checker: RTL and testbench

Synthesizable, parametrised self-checking harness for an N-input, 1-output combinational gate under test.
- On start, sweeps every input vector 0..2^N_IN-1 onto dut_in and waits a programmable settle time.
- Compares dut_out against a golden function selected by MODE, counts mismatches, and reports pass/fail.
- Used on-board and in simulation to qualify the gate-level library (nand/nor/and/or/xor) feeding the processor datapath.

---
 rtl/truth_table_checker.sv | 129 ++++++++++++
 tb/tb_truth_table_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sweeps every N_IN-bit vector into a 1-output gate and checks it against a MODE-selected golden.
// Optional TTC_STOP_ON_FAIL_EN: finish the sweep at the first mismatch.
module truth_table_checker #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic [N_IN-1:0]  fvec_q, fvec_d;
  logic             pass_q, pass_d;
  logic             expected, mismatch, stop_now;

  always_comb begin
    case (MODE)
      1:       expected = &dut_in_q;
      2:       expected = |dut_in_q;
      3:       expected = ~|dut_in_q;
      4:       expected = ^dut_in_q;
      default: expected = ~&dut_in_q;
    endcase
  end

  assign mismatch = (state_q == StCheck) && (dut_out != expected);
`ifdef TTC_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StSettle;
          dut_in_d = '0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
          cnt_d    = SettleInit;
          pass_d   = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d = cnt_q - 1'b1;
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = dut_in_q;
          end
        end
        // pass uses err_d so a mismatch on the final vector is counted
        if (stop_now) begin
          state_d = StDone;
          pass_d  = 1'b0;
        end else if (dut_in_q == '1) begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = StSettle;
          dut_in_d = dut_in_q + 1'b1;
          cnt_d    = SettleInit;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      dut_in_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = (state_q == StSettle) || (state_q == StCheck);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Six checker instances (varied N_IN/MODE/SETTLE/ERR_W) driven by gates with random planted faults.
module tb_truth_table_checker;

  localparam int NumK = 6;
  localparam int NI [NumK] = '{2, 3, 1, 4, 3, 3};
  localparam int MO [NumK] = '{0, 4, 1, 2, 3, 7};
  localparam int ST [NumK] = '{1, 3, 1, 2, 1, 2};
  localparam int EW [NumK] = '{8, 2, 4, 3, 2, 8};

  logic clock, reset, start;
  logic [15:0] flip [NumK];
  logic [NumK-1:0] busy, done, pass, fvld;
  logic [7:0] din_w [NumK];
  logic [7:0] ec_w [NumK];
  logic [7:0] fv_w [NumK];

  int n_pass = 0;
  int n_total = 0;
  int busy_cnt [NumK];
  int done_at [NumK];

  function automatic logic gold(input int mode, input int n, input int v);
    int all_ones = (1 << n) - 1;
    case (mode)
      1:       return v == all_ones;
      2:       return v != 0;
      3:       return v == 0;
      4:       return ($countones(v) % 2) == 1;
      default: return v != all_ones;
    endcase
  endfunction

  for (genvar k = 0; k < NumK; k++) begin : g_dut
    logic [NI[k]-1:0] din, fvec;
    logic [EW[k]-1:0] ec;
    logic dout;
    assign dout = gold(MO[k], NI[k], int'(din)) ^ flip[k][din];
    truth_table_checker #(.N_IN(NI[k]), .MODE(MO[k]), .SETTLE(ST[k]), .ERR_W(EW[k])) u_dut (
      .clock(clock), .reset(reset), .start(start), .dut_out(dout), .dut_in(din),
      .busy(busy[k]), .done(done[k]), .pass(pass[k]), .err_count(ec),
      .fail_valid(fvld[k]), .fail_vec(fvec)
    );
    assign din_w[k] = 8'(din);
    assign ec_w[k]  = 8'(ec);
    assign fv_w[k]  = 8'(fvec);
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < NumK; k++) begin
      check({tag, "_busy"}, k, 32'(busy[k]), 0);
      check({tag, "_done"}, k, 32'(done[k]), 0);
      check({tag, "_pass"}, k, 32'(pass[k]), 0);
      check({tag, "_fvld"}, k, 32'(fvld[k]), 0);
      check({tag, "_din"}, k, 32'(din_w[k]), 0);
      check({tag, "_err"}, k, 32'(ec_w[k]), 0);
      check({tag, "_fvec"}, k, 32'(fv_w[k]), 0);
    end
  endtask

  task automatic set_flips(input int kind);
    for (int k = 0; k < NumK; k++) begin
      int nv = 1 << NI[k];
      logic [15:0] mask = 16'((1 << nv) - 1);
      case (kind)
        0:       flip[k] = '0;
        1:       flip[k] = 16'(1) << $urandom_range(nv - 1);
        2:       flip[k] = mask;
        default: flip[k] = 16'($urandom) & mask;
      endcase
    end
  endtask

  task automatic sample(input int cyc);
    for (int k = 0; k < NumK; k++) begin
      if (busy[k]) busy_cnt[k]++;
      if (done[k] && done_at[k] < 0) done_at[k] = cyc;
    end
  endtask

  task automatic run_sweep(input int kind, input bit inject);
    int cyc = 0;
    set_flips(kind);
    for (int k = 0; k < NumK; k++) begin
      busy_cnt[k] = 0;
      done_at[k] = -1;
    end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    sample(0);
    while (!(&done) && cyc < 200) begin
      // lands on edge 2, where every instance is still mid-sweep
      if (inject && cyc == 1) start = 1'b1;
      @(posedge clock);
      #1;
      cyc++;
      start = 1'b0;
      sample(cyc);
    end
    check("timeout", 0, 32'(&done), 1);
    repeat (3) begin
      @(posedge clock);
      #1;
      sample(cyc);
    end
    for (int k = 0; k < NumK; k++) begin
      int nv = 1 << NI[k];
      int nerr = 0;
      int first = -1;
      int sat = (1 << EW[k]) - 1;
      int exp_t, exp_err, exp_din;
      for (int v = 0; v < nv; v++) begin
        if (flip[k][v]) begin
          nerr++;
          if (first < 0) first = v;
        end
      end
      exp_t   = nv * (ST[k] + 1);
      exp_err = (nerr > sat) ? sat : nerr;
      exp_din = nv - 1;
`ifdef TTC_STOP_ON_FAIL_EN
      if (nerr > 0) begin
        exp_t   = (first + 1) * (ST[k] + 1);
        exp_err = 1;
        exp_din = first;
      end
`endif
      check("done_edge", k, 32'(done_at[k]), 32'(exp_t));
      check("busy_cycles", k, 32'(busy_cnt[k]), 32'(exp_t));
      check("done_held", k, 32'(done[k]), 1);
      check("pass", k, 32'(pass[k]), 32'(nerr == 0));
      check("err_count", k, 32'(ec_w[k]), 32'(exp_err));
      check("fail_valid", k, 32'(fvld[k]), 32'(nerr > 0));
      check("fail_vec", k, 32'(fv_w[k]), 32'((nerr > 0) ? first : 0));
      check("dut_in", k, 32'(din_w[k]), 32'(exp_din));
    end
  endtask

  initial begin
    int kinds [10] = '{0, 2, 0, 1, 3, 3, 1, 3, 2, 0};
    reset = 1'b1;
    start = 1'b0;
    set_flips(0);
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_sweep(kinds[i], i[0]);

    // Async reset mid-sweep must clear everything before the next clock edge
    set_flips(2);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_cleared("mid_reset");
    @(negedge clock);
    reset = 1'b0;

    run_sweep(3, 1'b0);
    run_sweep(0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
